// File: rtl/spi_slave_responder_if.sv
// SPI responder bus: master pads plus the TX/RX word streams.
interface spi_slave_responder_if #(
    parameter int SPI_SS_NB = 8,
    parameter int MAX_LEN   = 32
);
    logic [SPI_SS_NB-1:0] ss_pad_o;
    logic                 sclk_pad_o;
    logic                 mosi_pad_o;
    logic                 miso_pad_i;
    logic                 miso_oe;
    logic [MAX_LEN-1:0]   tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [MAX_LEN-1:0]   rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport slave (
        input  ss_pad_o, sclk_pad_o, mosi_pad_o, tx_data, tx_valid, rx_ready,
        output miso_pad_i, miso_oe, tx_ready, rx_data, rx_valid
    );

    modport master (
        output ss_pad_o, sclk_pad_o, mosi_pad_o, tx_data, tx_valid, rx_ready,
        input  miso_pad_i, miso_oe, tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_responder.sv
// Oversampling SPI slave: all CPOL/CPHA modes, runtime word length and bit
// order, multi-word bursts under one SS, valid/ready TX and RX word streams.
module spi_slave_responder #(
    parameter int                 SPI_SS_NB = 8,
    parameter int                 SLAVE_IDX = 0,
    parameter int                 MAX_LEN   = 32,
    parameter int                 LEN_W     = $clog2(MAX_LEN),
    parameter logic [MAX_LEN-1:0] TX_IDLE   = MAX_LEN'('hFFFF_FFFF)
) (
    input  logic                 spi_clk,
    input  logic                 spi_rst,
    spi_slave_responder_if.slave bus,
    input  logic                 cfg_cpol,
    input  logic                 cfg_cpha,
    input  logic                 cfg_lsb,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 clr_err,
    output logic                 busy,
    output logic                 overrun,
    output logic                 underrun
);
    if (SLAVE_IDX < 0 || SLAVE_IDX >= SPI_SS_NB) begin : g_bad_idx
        $error("SLAVE_IDX outside ss_pad_o");
    end

    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [1:0]         ss_sync, sclk_sync, mosi_sync;
    logic               ss_d, sclk_d;
    logic               cpol_q, cpha_q, lsb_q;
    logic [LEN_W-1:0]   len_q, bitcnt, txcnt, tx_idx, first_idx;
    logic [MAX_LEN-1:0] txsh, rxsh, rx_nxt, ld_word;
    logic               reload_pend, miso_q;
    logic               ss_hi, ss_fall, sclk_rise, sclk_fall;
    logic               lead_edge, trail_edge, sample_edge, drive_edge;
    logic               word_done, reload_now, load_ok;

    // Pad synchronisers; SS idles high so no false select after reset.
    always_ff @(posedge spi_clk or negedge spi_rst) begin
        if (!spi_rst) begin
            ss_sync   <= 2'b11;
            ss_d      <= 1'b1;
            sclk_sync <= '0;
            sclk_d    <= 1'b0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[0], bus.ss_pad_o[SLAVE_IDX]};
            sclk_sync <= {sclk_sync[0], bus.sclk_pad_o};
            mosi_sync <= {mosi_sync[0], bus.mosi_pad_o};
            ss_d      <= ss_sync[1];
            sclk_d    <= sclk_sync[1];
        end
    end

    assign ss_hi       = ss_sync[1];
    assign ss_fall     = ss_d && !ss_sync[1];
    assign sclk_rise   = sclk_sync[1] && !sclk_d;
    assign sclk_fall   = !sclk_sync[1] && sclk_d;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign drive_edge  = cpha_q ? lead_edge : trail_edge;

    assign word_done  = (state_q == ACTIVE) && !ss_hi && sample_edge && (bitcnt == len_q);
    assign reload_now = (state_q == ACTIVE) && !ss_hi && drive_edge && reload_pend;
    assign load_ok    = (state_q == LOAD) && !ss_hi;
    assign ld_word    = bus.tx_valid ? bus.tx_data : TX_IDLE;
    assign tx_idx     = lsb_q ? txcnt : LEN_W'(len_q - txcnt);
    assign first_idx  = lsb_q ? '0 : len_q;

    assign busy           = (state_q != IDLE);
    assign bus.miso_oe    = (state_q != IDLE);
    assign bus.miso_pad_i = miso_q;

    // Receive shifter: MSB-first shifts in at bit 0, LSB-first drops bit at its index.
    always_comb begin
        rx_nxt = rxsh;
        if (lsb_q) rx_nxt[bitcnt] = mosi_sync[1];
        else       rx_nxt = {rxsh[MAX_LEN-2:0], mosi_sync[1]};
    end

    // State register.
    always_ff @(posedge spi_clk or negedge spi_rst) begin
        if (!spi_rst) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and the one-cycle tx_ready strobe.
    always_comb begin
        state_d      = state_q;
        bus.tx_ready = 1'b0;
        case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD: begin
                state_d      = ss_hi ? IDLE : ACTIVE;
                bus.tx_ready = !ss_hi && bus.tx_valid;
            end
            ACTIVE: begin
                if (ss_hi)                                     state_d = IDLE;
                else if ((word_done && !cpha_q) || reload_now) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Config capture, shift registers, bit counters and MISO drive.
    always_ff @(posedge spi_clk or negedge spi_rst) begin
        if (!spi_rst) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            len_q       <= '0;
            txsh        <= '0;
            rxsh        <= '0;
            bitcnt      <= '0;
            txcnt       <= '0;
            reload_pend <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        cpol_q <= cfg_cpol;
                        cpha_q <= cfg_cpha;
                        lsb_q  <= cfg_lsb;
                        len_q  <= cfg_len;
                    end
                end
                LOAD: begin
                    if (ss_hi) begin
                        miso_q      <= 1'b0;
                        reload_pend <= 1'b0;
                    end else begin
                        txsh        <= ld_word;
                        rxsh        <= '0;
                        bitcnt      <= '0;
                        reload_pend <= 1'b0;
                        // cpha=0 needs bit 0 before the first sample; a cpha=1 reload was
                        // triggered by the drive edge that owns bit 0 of this word.
                        if (!cpha_q || reload_pend) begin
                            miso_q <= ld_word[first_idx];
                            txcnt  <= LEN_W'(1);
                        end else begin
                            txcnt  <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_hi) begin
                        miso_q      <= 1'b0;
                        reload_pend <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rxsh <= rx_nxt;
                            if (bitcnt == len_q) begin
                                bitcnt      <= '0;
                                reload_pend <= cpha_q;
                            end else begin
                                bitcnt <= bitcnt + LEN_W'(1);
                            end
                        end
                        // With cpha=0 the drive edge before any sample belongs to the old word.
                        if (drive_edge && !reload_pend && (cpha_q || bitcnt != '0)) begin
                            miso_q <= txsh[tx_idx];
                            txcnt  <= txcnt + LEN_W'(1);
                        end
                    end
                end
                default: miso_q <= 1'b0;
            endcase
        end
    end

    // RX word handoff and sticky error flags; a new error beats clr_err.
    always_ff @(posedge spi_clk or negedge spi_rst) begin
        if (!spi_rst) begin
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
            if (word_done && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= rx_nxt;
                bus.rx_valid <= 1'b1;
            end
            if (clr_err) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end
            if (word_done && bus.rx_valid && !bus.rx_ready) overrun  <= 1'b1;
            if (load_ok && !bus.tx_valid)                   underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: bit-banged SPI master with RX/MISO scoreboards.
module tb_spi_slave_responder;
    localparam int HP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cpol, cpha, lsb, clr_err;
    logic [4:0] len;
    logic       busy, overrun, underrun;

    spi_slave_responder_if #(.SPI_SS_NB(8), .MAX_LEN(32)) bus();

    spi_slave_responder #(.SPI_SS_NB(8), .SLAVE_IDX(0), .MAX_LEN(32)) dut (
        .spi_clk(clk), .spi_rst(rst_n), .bus(bus),
        .cfg_cpol(cpol), .cfg_cpha(cpha), .cfg_lsb(lsb), .cfg_len(len),
        .clr_err(clr_err), .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    int n_chk = 0, n_pass = 0;
    int tx_base = 0, tx_n = 0, txr_total = 0;
    logic [31:0] tx_words [4];
    logic [31:0] mo_words [4];
    logic [31:0] got_words[4];
    logic [31:0] exp_rx[$];
    logic [31:0] exp_miso[$];

    // TX source: words offered in order, valid while tx_n are not yet consumed.
    assign bus.tx_data  = tx_words[(txr_total - tx_base) & 3];
    assign bus.tx_valid = ((txr_total - tx_base) < tx_n);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: pops RX scoreboard on handshake, counts tx_ready pulses.
    always begin
        @(negedge clk); #1;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", 32'(exp_rx.size()), 32'd1);
            else                    chk("rx_word", bus.rx_data, exp_rx.pop_front());
        end
        if (bus.tx_ready === 1'b1) begin
            @(posedge clk); #1;
            txr_total++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic set_mode(input bit pl, input bit ph, input bit ls, input int l);
        cpol = pl; cpha = ph; lsb = ls; len = l[4:0];
        bus.sclk_pad_o = pl;
        tick(4);
    endtask

    task automatic start_tx(input int n);
        tx_base = txr_total;
        tx_n    = n;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1; tick(1);
        clr_err = 1'b0; tick(1);
    endtask

    // Master: nw words, optional stop after stop_at bits (SS high or reset).
    task automatic spi_burst(input int nw, input int stop_at, input bit rst_at_stop);
        int  done_bits = 0;
        bit  stopped = 0;
        int  b;
        bus.sclk_pad_o = cpol;
        bus.ss_pad_o   = 8'hFE;
        tick(10);
        for (int w = 0; w < nw && !stopped; w++) begin
            got_words[w] = '0;
            for (int k = 0; k <= int'(len) && !stopped; k++) begin
                b = lsb ? k : int'(len) - k;
                if (!cpha) begin
                    bus.mosi_pad_o = mo_words[w][b];
                    tick(HP);
                    got_words[w][b] = bus.miso_pad_i;
                    bus.sclk_pad_o = ~cpol;
                    tick(HP);
                    bus.sclk_pad_o = cpol;
                end else begin
                    bus.sclk_pad_o = ~cpol;
                    bus.mosi_pad_o = mo_words[w][b];
                    tick(HP);
                    got_words[w][b] = bus.miso_pad_i;
                    bus.sclk_pad_o = cpol;
                    tick(HP);
                end
                done_bits++;
                if (done_bits == stop_at) stopped = 1;
            end
        end
        if (!cpha) tick(HP);
        if (stopped && rst_at_stop) begin
            chk("pre_rst_busy", busy, 1);
            chk("pre_rst_underrun", underrun, 1);
            rst_n = 1'b0;
            tick(2);
        end else begin
            bus.ss_pad_o = '1;
            tick(12);
        end
    endtask

    task automatic chk_miso(input string tag, input int nw);
        for (int w = 0; w < nw; w++) begin
            if (exp_miso.size() == 0) chk({tag, "_missing"}, 32'(exp_miso.size()), 32'd1);
            else                      chk(tag, got_words[w], exp_miso.pop_front());
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_rx.size() != 0; i++) tick(1);
        chk(tag, 32'(exp_rx.size()), 32'd0);
    endtask

    initial begin
        bus.ss_pad_o = '1; bus.sclk_pad_o = 1'b0; bus.mosi_pad_o = 1'b0;
        bus.rx_ready = 1'b1; clr_err = 1'b0;
        cpol = 0; cpha = 0; lsb = 0; len = 5'd7;
        for (int i = 0; i < 4; i++) begin tx_words[i] = '0; mo_words[i] = '0; end
        tick(3);
        chk("rst_miso", bus.miso_pad_i, 0);
        chk("rst_oe", bus.miso_oe, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        tick(3);

        // Mode 0, 8-bit MSB-first single word
        set_mode(0, 0, 0, 7);
        tx_words[0] = 32'hA5; mo_words[0] = 32'h3C; start_tx(1);
        exp_miso.push_back(32'hA5); exp_rx.push_back(32'h3C);
        spi_burst(1, -1, 0);
        chk_miso("m0_miso", 1);
        drain("m0_rx");
        chk("m0_tx_ready", 32'(txr_total - tx_base), 1);
        chk("m0_idle_busy", busy, 0);
        chk("m0_idle_oe", bus.miso_oe, 0);

        // Modes 1..3, 32-bit LSB-first
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1, 31);
            tx_words[0] = 32'hDEADBEEF; mo_words[0] = 32'h12345678; start_tx(1);
            exp_miso.push_back(32'hDEADBEEF); exp_rx.push_back(32'h12345678);
            spi_burst(1, -1, 0);
            chk_miso($sformatf("mode%0d_miso", m), 1);
            drain($sformatf("mode%0d_rx", m));
            chk($sformatf("mode%0d_tx_ready", m), 32'(txr_total - tx_base), 1);
        end

        // Mode 3 burst, three 16-bit MSB-first words, TX always valid
        set_mode(1, 1, 0, 15);
        tx_words[0] = 32'h1111; tx_words[1] = 32'h2222; tx_words[2] = 32'h3333; tx_words[3] = 32'h4444;
        mo_words[0] = 32'hA1B2; mo_words[1] = 32'hC3D4; mo_words[2] = 32'hE5F6;
        start_tx(4);
        for (int w = 0; w < 3; w++) begin
            exp_miso.push_back(tx_words[w]); exp_rx.push_back(mo_words[w]);
        end
        spi_burst(3, -1, 0);
        chk_miso("burst_miso", 3);
        drain("burst_rx");
        chk("burst_tx_ready", 32'(txr_total - tx_base), 3);

        // Underrun: no TX word at SS assert
        clr_pulse();
        chk("pre_ur_underrun", underrun, 0);
        chk("pre_ur_overrun", overrun, 0);
        set_mode(0, 0, 0, 7);
        start_tx(0); mo_words[0] = 32'h5A;
        exp_miso.push_back(32'hFF); exp_rx.push_back(32'h5A);
        spi_burst(1, -1, 0);
        chk_miso("ur_miso", 1);
        drain("ur_rx");
        chk("ur_underrun", underrun, 1);
        chk("ur_tx_ready", 32'(txr_total - tx_base), 0);
        clr_pulse();
        chk("ur_cleared", underrun, 0);

        // Overrun: consumer stalled across a 2-word mode 1 burst
        set_mode(0, 1, 0, 7);
        tx_words[0] = 32'h11; tx_words[1] = 32'h22; start_tx(2);
        mo_words[0] = 32'h81; mo_words[1] = 32'h42;
        exp_miso.push_back(32'h11); exp_miso.push_back(32'h22);
        exp_rx.push_back(32'h81);
        bus.rx_ready = 1'b0;
        spi_burst(2, -1, 0);
        chk_miso("ov_miso", 2);
        chk("ov_rx_valid", bus.rx_valid, 1);
        chk("ov_rx_held", bus.rx_data, 32'h81);
        chk("ov_overrun", overrun, 1);
        chk("ov_tx_ready", 32'(txr_total - tx_base), 2);
        bus.rx_ready = 1'b1;
        drain("ov_rx");
        tick(2);
        chk("ov_rx_consumed", bus.rx_valid, 0);
        clr_pulse();
        chk("ov_cleared", overrun, 0);

        // SS deasserted after 5 of 8 bits
        set_mode(0, 0, 0, 7);
        tx_words[0] = 32'hC3; mo_words[0] = 32'hFF; start_tx(1);
        spi_burst(1, 5, 0);
        drain("abort_no_rx");
        chk("abort_rx_valid", bus.rx_valid, 0);
        chk("abort_tx_ready", 32'(txr_total - tx_base), 1);
        chk("abort_busy", busy, 0);
        chk("abort_oe", bus.miso_oe, 0);
        chk("abort_miso", bus.miso_pad_i, 0);

        // Reset asserted mid-word with SS still low
        clr_pulse();
        start_tx(0); mo_words[0] = 32'hFF;
        spi_burst(1, 3, 1);
        chk("midrst_miso", bus.miso_pad_i, 0);
        chk("midrst_oe", bus.miso_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_ready", bus.tx_ready, 0);
        chk("midrst_rx_valid", bus.rx_valid, 0);
        chk("midrst_rx_data", bus.rx_data, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_underrun", underrun, 0);
        bus.ss_pad_o = '1;
        tick(4);
        rst_n = 1'b1;
        tick(6);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rx_valid", bus.rx_valid, 0);

        chk("rx_queue_empty", 32'(exp_rx.size()), 0);
        chk("miso_queue_empty", 32'(exp_miso.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
